goodie_spawner: RTL and testbench
=================================

// Module: goodie_spawner
// PURPOSE
//  Upstream feeder for the goodie collector: owns the 9 goodie slots, launches them one by one off the right screen edge,
//  scrolls them left once per frame and parks them when collected or missed. Drives goodie_pos_x1..9/y1..9 consumed by
//  collision/collection logic and the renderer; takes back the collector's sticky sig_goodie_1..9 flags as collected[8:0].
// PARAMETERS
//  SCREEN_W    1280      visible width (px); launch x
//  Y_MIN       64        lowest spawn y (px)
//  Y_MAX       900       highest spawn y; require Y_MAX-Y_MIN+1 in [512,1024]
//  SPEED       2         px moved left per frame_tick
//  SPAWN_GAP   60        frame_ticks between launches (>=1)
//  LFSR_SEED   16'hACE1  LFSR reset value (non-zero)
// PORTS
//  clk             in   1    system clock
//  game_start      in   1    synchronous active-high reset (new game)
//  play            in   1    1 = game running; 0 = paused/frozen
//  frame_tick      in   1    one-cycle pulse per video frame
//  collected       in   9    bit i-1 = sig_goodie_i from collector (sticky until game_start)
//  goodie_pos_xN   out  11   N=1..9, slot x (top-left), registered
//  goodie_pos_yN   out  10   N=1..9, slot y (top-left), registered
//  goodie_active   out  9    bit i = slot i+1 on screen and uncollected (render enable)
//  missed_count    out  4    slots that left screen uncollected
//  course_done     out  1    one-cycle pulse when all 9 slots reach DONE
// BEHAVIOUR
//  - Reset (game_start=1, overrides all): every x=PARK_X(2047), y=PARK_Y(1023), slot state WAIT, goodie_active=0,
//    missed_count=0, course_done=0, spawn counter=0, launch index=0, LFSR=LFSR_SEED. Effective next edge; valid mid-course.
//  - Slot FSM per slot: WAIT -> ACTIVE (launch) -> DONE (collected or exited). DONE is terminal until game_start.
//  - LFSR: 16-bit Galois, mask 16'hB400, advances every non-reset cycle regardless of play.
//  - Spawn: on frame_tick&play, while launch index<9: if counter==SPAWN_GAP-1 then launch slot[index], index+1,
//    counter=0; else counter+1. After 9 launches counter holds. First launch after SPAWN_GAP ticks of play.
//  - Launch values: x=SCREEN_W; r=lfsr[9:0]; y = (r<=Y_MAX-Y_MIN) ? Y_MIN+r : Y_MIN+r-(Y_MAX-Y_MIN+1). Always in [Y_MIN,Y_MAX].
//  - Scroll: ACTIVE slot on frame_tick&play: x>=SPEED -> x-=SPEED (no wrap); else -> DONE, park, missed_count+1.
//  - Collect: ACTIVE slot with collected bit=1 -> DONE, park next cycle, missed_count unchanged. Takes priority over
//    scroll/exit in same cycle. collected on a WAIT/DONE slot is ignored.
//  - Launch and scroll of other slots in same tick are independent; a slot launched this tick does not also move.
//  - play=0: positions, counter, states frozen; collected still parks ACTIVE slots.
//  - goodie_active[i] = (state==ACTIVE), registered with positions; parked coordinates are never inside play field.
//  - course_done: pulse the cycle after the last slot enters DONE; fires at most once per game.
//  - missed_count saturates at 9 (cannot exceed by construction). Latency: all outputs one cycle after causing input.
// STRUCTURE
//  - goodie_pkg: N_GOODIES=9, GOODIE_SIZE=20, PARK_X, PARK_Y, slot_state_t {WAIT,ACTIVE,DONE}, LFSR mask.
//  - Sub-module goodie_lfsr (16-bit Galois, seed param, clk/game_start); slot array via generate loop in top.
//  - Flat x/y ports kept to match collector interface; internally arrays.
// TESTING (bench uses SPAWN_GAP=4, SPEED=2)
//  1 Reset: game_start 1 cycle -> all x=2047, y=1023, goodie_active=0, missed_count=0, course_done=0.
//  2 Launch: play=1, 4 frame_ticks -> x1=1280, Y_MIN<=y1<=Y_MAX, active=9'b000000001; 5th tick -> x1=1278.
//  3 Collect: collected[0]=1 with frame_tick same cycle -> next cycle x1=2047, active[0]=0, missed_count unchanged.
//  4 Exit: slot at x=1, tick -> parked, missed_count+1; slot at x=2 -> x=0 and stays ACTIVE.
//  5 Pause: play=0, 10 ticks -> positions/counter unchanged; play=1 resumes exactly where stopped.
//  6 Course end + reset: all 9 done -> course_done single pulse; game_start mid-course -> all parked next cycle, relaunch ok.

Source files
------------

// File: rtl/goodie_pkg.sv
// Shared constants, slot state encoding and helpers for the goodie spawner.
// Parked coordinates sit outside the visible play field.
package goodie_pkg;

  localparam int          N_GOODIES   = 9;
  localparam int          GOODIE_SIZE = 20;
  localparam logic [10:0] PARK_X      = 11'd2047;
  localparam logic [9:0]  PARK_Y      = 10'd1023;
  localparam logic [15:0] LFSR_MASK   = 16'hB400;

  typedef enum logic [1:0] {
    SLOT_WAIT   = 2'd0,
    SLOT_ACTIVE = 2'd1,
    SLOT_DONE   = 2'd2
  } slot_state_t;

  function automatic logic [3:0] count_ones(input logic [N_GOODIES-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int k = 0; k < N_GOODIES; k++) begin
      c = c + 4'(v[k]);
    end
    return c;
  endfunction

endpackage

// File: rtl/goodie_lfsr.sv
// 16-bit Galois LFSR used as the spawn-height source.
// It steps every cycle, independent of play, so that heights vary with timing.
module goodie_lfsr
  import goodie_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk_i,
  input  logic       game_start_i,
  output logic [9:0] rnd_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
  end

  always_ff @(posedge clk_i) begin
    if (game_start_i) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rnd_o = lfsr_q[9:0];

endmodule

// File: rtl/goodie_spawner.sv
// Owns the goodie slots: launches them off the right edge, scrolls them left per frame,
// and parks them when collected or missed. Flat x/y ports match the collector interface.
module goodie_spawner
  import goodie_pkg::*;
#(
  parameter int          SCREEN_W  = 1280,
  parameter int          Y_MIN     = 64,
  parameter int          Y_MAX     = 900,
  parameter int          SPEED     = 2,
  parameter int          SPAWN_GAP = 60,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 game_start_i,
  input  logic                 play_i,
  input  logic                 frame_tick_i,
  input  logic [N_GOODIES-1:0] collected_i,
  output logic [10:0]          goodie_pos_x1_o,
  output logic [10:0]          goodie_pos_x2_o,
  output logic [10:0]          goodie_pos_x3_o,
  output logic [10:0]          goodie_pos_x4_o,
  output logic [10:0]          goodie_pos_x5_o,
  output logic [10:0]          goodie_pos_x6_o,
  output logic [10:0]          goodie_pos_x7_o,
  output logic [10:0]          goodie_pos_x8_o,
  output logic [10:0]          goodie_pos_x9_o,
  output logic [9:0]           goodie_pos_y1_o,
  output logic [9:0]           goodie_pos_y2_o,
  output logic [9:0]           goodie_pos_y3_o,
  output logic [9:0]           goodie_pos_y4_o,
  output logic [9:0]           goodie_pos_y5_o,
  output logic [9:0]           goodie_pos_y6_o,
  output logic [9:0]           goodie_pos_y7_o,
  output logic [9:0]           goodie_pos_y8_o,
  output logic [9:0]           goodie_pos_y9_o,
  output logic [N_GOODIES-1:0] goodie_active_o,
  output logic [3:0]           missed_count_o,
  output logic                 course_done_o
);

  localparam int Y_SPAN = Y_MAX - Y_MIN + 1;

  logic                 tick_play;
  logic [9:0]           rnd;
  logic [9:0]           launch_y;
  logic                 launch;
  logic [15:0]          cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [3:0]           missed_q, missed_d;
  logic                 fired_q, fired_d;
  logic                 course_done_q, course_done_d;
  logic [N_GOODIES-1:0] exit_w, done_d_w, active_w;
  logic [10:0]          x_w [N_GOODIES];
  logic [9:0]           y_w [N_GOODIES];

  assign tick_play = frame_tick_i & play_i;

  goodie_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i        (clk_i),
    .game_start_i (game_start_i),
    .rnd_o        (rnd)
  );

  // Fold the 10-bit random value into [Y_MIN, Y_MAX]; span >= 512 makes one subtraction enough.
  always_comb begin
    if (rnd <= 10'(Y_SPAN - 1)) begin
      launch_y = 10'(11'(Y_MIN) + 11'(rnd));
    end else begin
      launch_y = 10'(11'(Y_MIN) + 11'(rnd) - 11'(Y_SPAN));
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    launch = 1'b0;
    if (tick_play && (idx_q < 4'(N_GOODIES))) begin
      if (cnt_q == 16'(SPAWN_GAP - 1)) begin
        launch = 1'b1;
        idx_d  = idx_q + 4'd1;
        cnt_d  = 16'd0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  for (genvar i = 0; i < N_GOODIES; i++) begin : g_slot
    slot_state_t st_q, st_d;
    logic [10:0] sx_q, sx_d;
    logic [9:0]  sy_q, sy_d;
    logic        ex;

    always_comb begin
      st_d = st_q;
      sx_d = sx_q;
      sy_d = sy_q;
      ex   = 1'b0;
      case (st_q)
        SLOT_WAIT: begin
          if (launch && (idx_q == 4'(i))) begin
            st_d = SLOT_ACTIVE;
            sx_d = 11'(SCREEN_W);
            sy_d = launch_y;
          end
        end
        SLOT_ACTIVE: begin
          if (collected_i[i]) begin
            st_d = SLOT_DONE;
            sx_d = PARK_X;
            sy_d = PARK_Y;
          end else if (tick_play) begin
            if (sx_q >= 11'(SPEED)) begin
              sx_d = sx_q - 11'(SPEED);
            end else begin
              st_d = SLOT_DONE;
              sx_d = PARK_X;
              sy_d = PARK_Y;
              ex   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (game_start_i) begin
        st_q <= SLOT_WAIT;
        sx_q <= PARK_X;
        sy_q <= PARK_Y;
      end else begin
        st_q <= st_d;
        sx_q <= sx_d;
        sy_q <= sy_d;
      end
    end

    assign x_w[i]      = sx_q;
    assign y_w[i]      = sy_q;
    assign exit_w[i]   = ex;
    assign done_d_w[i] = (st_d == SLOT_DONE);
    assign active_w[i] = (st_q == SLOT_ACTIVE);
  end

  always_comb begin
    logic [4:0] sum;
    sum      = {1'b0, missed_q} + {1'b0, count_ones(exit_w)};
    missed_d = (sum > 5'd9) ? 4'd9 : sum[3:0];
    // Pulse once: fired_q blocks repeats until the next game.
    course_done_d = (&done_d_w) & ~fired_q;
    fired_d       = fired_q | (&done_d_w);
  end

  always_ff @(posedge clk_i) begin
    if (game_start_i) begin
      cnt_q         <= 16'd0;
      idx_q         <= 4'd0;
      missed_q      <= 4'd0;
      fired_q       <= 1'b0;
      course_done_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      missed_q      <= missed_d;
      fired_q       <= fired_d;
      course_done_q <= course_done_d;
    end
  end

  assign goodie_active_o = active_w;
  assign missed_count_o  = missed_q;
  assign course_done_o   = course_done_q;

  assign goodie_pos_x1_o = x_w[0];
  assign goodie_pos_x2_o = x_w[1];
  assign goodie_pos_x3_o = x_w[2];
  assign goodie_pos_x4_o = x_w[3];
  assign goodie_pos_x5_o = x_w[4];
  assign goodie_pos_x6_o = x_w[5];
  assign goodie_pos_x7_o = x_w[6];
  assign goodie_pos_x8_o = x_w[7];
  assign goodie_pos_x9_o = x_w[8];
  assign goodie_pos_y1_o = y_w[0];
  assign goodie_pos_y2_o = y_w[1];
  assign goodie_pos_y3_o = y_w[2];
  assign goodie_pos_y4_o = y_w[3];
  assign goodie_pos_y5_o = y_w[4];
  assign goodie_pos_y6_o = y_w[5];
  assign goodie_pos_y7_o = y_w[6];
  assign goodie_pos_y8_o = y_w[7];
  assign goodie_pos_y9_o = y_w[8];

endmodule

// File: tb/tb_goodie_spawner.sv
// Directed bench for goodie_spawner with SPAWN_GAP=4, SPEED=2.
// Slot k (1-based) launches on play tick 4k and exits 641 ticks later.
module tb_goodie_spawner;

  logic        clk_i = 1'b0;
  logic        game_start_i, play_i, frame_tick_i;
  logic [8:0]  collected_i;
  logic [10:0] x1, x2, x3, x4, x5, x6, x7, x8, x9;
  logic [9:0]  y1, y2, y3, y4, y5, y6, y7, y8, y9;
  logic [8:0]  active;
  logic [3:0]  missed;
  logic        course_done;
  logic [10:0] xs [9];
  logic [9:0]  ys [9];

  int total = 0;
  int bad   = 0;

  logic [15:0] m_lfsr;
  logic [15:0] l_at;

  always #5 clk_i = ~clk_i;

  goodie_spawner #(
    .SCREEN_W(1280), .Y_MIN(64), .Y_MAX(900), .SPEED(2), .SPAWN_GAP(4), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk_i(clk_i), .game_start_i(game_start_i), .play_i(play_i), .frame_tick_i(frame_tick_i),
    .collected_i(collected_i),
    .goodie_pos_x1_o(x1), .goodie_pos_x2_o(x2), .goodie_pos_x3_o(x3),
    .goodie_pos_x4_o(x4), .goodie_pos_x5_o(x5), .goodie_pos_x6_o(x6),
    .goodie_pos_x7_o(x7), .goodie_pos_x8_o(x8), .goodie_pos_x9_o(x9),
    .goodie_pos_y1_o(y1), .goodie_pos_y2_o(y2), .goodie_pos_y3_o(y3),
    .goodie_pos_y4_o(y4), .goodie_pos_y5_o(y5), .goodie_pos_y6_o(y6),
    .goodie_pos_y7_o(y7), .goodie_pos_y8_o(y8), .goodie_pos_y9_o(y9),
    .goodie_active_o(active), .missed_count_o(missed), .course_done_o(course_done)
  );

  assign xs[0] = x1; assign xs[1] = x2; assign xs[2] = x3;
  assign xs[3] = x4; assign xs[4] = x5; assign xs[5] = x6;
  assign xs[6] = x7; assign xs[7] = x8; assign xs[8] = x9;
  assign ys[0] = y1; assign ys[1] = y2; assign ys[2] = y3;
  assign ys[3] = y4; assign ys[4] = y5; assign ys[5] = y6;
  assign ys[6] = y7; assign ys[7] = y8; assign ys[8] = y9;

  // Reference LFSR: right-shift Galois, mask B400, steps every non-reset cycle.
  always @(posedge clk_i) begin
    if (game_start_i) m_lfsr <= 16'hACE1;
    else              m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  function automatic int exp_y(input logic [15:0] l);
    int r;
    r = int'(l[9:0]);
    if (r <= 836) return 64 + r;
    return 64 + r - 837;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic tick();
    l_at = m_lfsr;
    frame_tick_i = 1'b1;
    @(posedge clk_i);
    #1;
    frame_tick_i = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick();
      cyc(1);
    end
  endtask

  task automatic check_all_parked(input string tag);
    for (int i = 0; i < 9; i++) begin
      check({tag, "_x"}, 32'(xs[i]), 32'd2047);
      check({tag, "_y"}, 32'(ys[i]), 32'd1023);
    end
    check({tag, "_active"}, 32'(active), 32'd0);
    check({tag, "_missed"}, 32'(missed), 32'd0);
    check({tag, "_done"},   32'(course_done), 32'd0);
  endtask

  initial begin
    game_start_i = 1'b1;
    play_i       = 1'b0;
    frame_tick_i = 1'b0;
    collected_i  = 9'd0;
    cyc(1);
    check_all_parked("reset");
    game_start_i = 1'b0;

    // Launch of slot 1 on the 4th tick
    play_i = 1'b1;
    ticks(3);
    check("prelaunch_active", 32'(active), 32'd0);
    tick();
    check("launch_x1", 32'(x1), 32'd1280);
    check("launch_y1", 32'(y1), 32'(exp_y(l_at)));
    check("launch_y1_range", 32'((y1 >= 10'd64) && (y1 <= 10'd900)), 32'd1);
    check("launch_active", 32'(active), 32'd1);
    cyc(1);
    tick();
    check("scroll_x1", 32'(x1), 32'd1278);
    cyc(1);

    // Pause: nothing moves, counter holds
    play_i = 1'b0;
    ticks(10);
    check("pause_x1", 32'(x1), 32'd1278);
    check("pause_active", 32'(active), 32'd1);
    play_i = 1'b1;
    ticks(1);
    check("resume_x1", 32'(x1), 32'd1276);
    ticks(1);
    check("resume_no_launch", 32'(active), 32'd1);
    tick();
    check("launch_x2", 32'(x2), 32'd1280);
    check("launch_y2", 32'(y2), 32'(exp_y(l_at)));
    check("launch2_active", 32'(active), 32'd3);
    check("tick8_x1", 32'(x1), 32'd1272);
    cyc(1);

    // Collect slot 1 in the same cycle as a frame tick
    collected_i[0] = 1'b1;
    tick();
    check("collect_x1", 32'(x1), 32'd2047);
    check("collect_y1", 32'(y1), 32'd1023);
    check("collect_active", 32'(active), 32'd2);
    check("collect_missed", 32'(missed), 32'd0);
    check("collect_x2", 32'(x2), 32'd1278);
    cyc(1);

    // Slot 2 runs to the left edge and exits
    ticks(637);
    tick();
    check("edge_x2_2", 32'(x2), 32'd2);
    check("edge_act2", 32'(active[1]), 32'd1);
    cyc(1);
    tick();
    check("edge_x2_0", 32'(x2), 32'd0);
    check("edge_act2_0", 32'(active[1]), 32'd1);
    check("edge_missed0", 32'(missed), 32'd0);
    cyc(1);
    tick();
    check("exit_x2", 32'(x2), 32'd2047);
    check("exit_y2", 32'(y2), 32'd1023);
    check("exit_missed", 32'(missed), 32'd1);
    check("exit_active", 32'(active), 32'h1FC);
    check("exit_x9", 32'(x9), 32'd54);
    cyc(1);

    // Course end
    ticks(27);
    check("pre_end_done", 32'(course_done), 32'd0);
    check("pre_end_missed", 32'(missed), 32'd7);
    check("pre_end_active", 32'(active), 32'h100);
    tick();
    check("end_done_pulse", 32'(course_done), 32'd1);
    check("end_missed", 32'(missed), 32'd8);
    check("end_active", 32'(active), 32'd0);
    cyc(1);
    check("end_done_drop", 32'(course_done), 32'd0);
    ticks(3);
    check("end_done_once", 32'(course_done), 32'd0);
    check("end_missed_hold", 32'(missed), 32'd8);

    // New game, then restart mid-course
    collected_i  = 9'd0;
    game_start_i = 1'b1;
    cyc(1);
    game_start_i = 1'b0;
    check_all_parked("newgame");
    ticks(3);
    tick();
    check("relaunch_x1", 32'(x1), 32'd1280);
    check("relaunch_y1", 32'(y1), 32'(exp_y(l_at)));
    check("relaunch_active", 32'(active), 32'd1);
    cyc(1);
    tick();
    check("relaunch_scroll", 32'(x1), 32'd1278);
    cyc(1);
    frame_tick_i = 1'b1;
    game_start_i = 1'b1;
    cyc(1);
    frame_tick_i = 1'b0;
    game_start_i = 1'b0;
    check_all_parked("midreset");
    ticks(3);
    check("midreset_nolaunch", 32'(active), 32'd0);
    tick();
    check("midreset_x1", 32'(x1), 32'd1280);
    check("midreset_y1", 32'(y1), 32'(exp_y(l_at)));
    check("midreset_active", 32'(active), 32'd1);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
